fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the MIPS32 5-stage pipeline; the producer for the decode stage.
//  - Owns the PC and fetches words from instruction memory over a req/ack handshake.
//  - Loads the IF/ID register (instruction, pc, pc_plus) that decode consumes.
//  - Honours stall from the hazard unit and redirect (taken branch / jump / jr) from decode.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  NOP       32'h0000_0000  word driven into IF/ID on reset/flush (sll $0,$0,0)
// PORTS
//  clk          in   1   clock; all state updates on rising edge
//  reset        in   1   asynchronous, active-low reset
//  stall        in   1   hazard unit: hold IF/ID and PC this cycle
//  redirect     in   1   decode: next_pc differs from sequential path, flush IF/ID
//  redirect_pc  in   32  target byte address; bits [1:0] ignored, forced 0
//  imem_req     out  1   fetch request; held high until imem_ack
//  imem_addr    out  32  word-aligned byte address; stable while imem_req high
//  imem_ack     in   1   one-cycle pulse: imem_rdata valid for imem_addr
//  imem_rdata   in   32  fetched instruction word
//  instruction  out  32  IF/ID: instruction to decode
//  pc           out  32  IF/ID: address of instruction
//  pc_plus      out  32  IF/ID: pc + 4, modulo 2^32
//  if_valid     out  1   IF/ID holds a real instruction (0 = bubble)
// BEHAVIOUR
//  - Reset (reset==0, async): fetch_pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=0,
//    instruction=NOP, pc=0, pc_plus=0, if_valid=0, hold buffer empty.
//  - States: IDLE -> RUN on first edge after reset release.
//    RUN: imem_req=1, imem_addr=req_addr. ack earliest one cycle after req rises.
//    HOLD: buffer holds an acked word; imem_req=0.
//    KILL: request outstanding but stale; response is discarded on ack.
//  - Priority per edge: stall > redirect > ack. Redirect during stall is ignored
//    (branch still sits in IF/ID); decode re-asserts it once stall drops.
//  - RUN, ack, !stall, !redirect: IF/ID <= {imem_rdata, req_addr, req_addr+4}, if_valid=1;
//    req_addr <= req_addr+4; stay RUN. Back-to-back acks give 1 instruction/cycle.
//  - RUN, ack, stall: word -> hold buffer, IF/ID unchanged, -> HOLD.
//  - RUN, no ack, stall: IF/ID unchanged, stay RUN.
//  - HOLD, !stall, !redirect: IF/ID <= buffer, if_valid=1, req_addr += 4, -> RUN.
//  - HOLD, stall: no change.
//  - Redirect (no stall): IF/ID <= NOP, if_valid=0; req_addr <= {redirect_pc[31:2],2'b00}.
//    RUN without ack this cycle -> KILL (request cannot be withdrawn; imem_addr held).
//    RUN with ack this cycle: word dropped -> RUN at target next cycle.
//    HOLD: buffer discarded -> RUN.
//  - KILL: ack -> RUN with imem_addr = stored target, no IF/ID load.
//    Second redirect in KILL overwrites target. Stall in KILL: stay KILL; ack still consumed.
//  - Address arithmetic wraps: 32'hFFFF_FFFC + 4 = 0. No alignment exceptions.
//  - imem_ack while imem_req==0 (IDLE/HOLD) is a protocol error and is ignored.
//  - Reset mid-transaction abandons outstanding request; late ack after reset is ignored
//    because state is IDLE.
// STRUCTURE
//  - Shared package pipeline_defs: NOP_INSTR, RESET_PC default, fetch state encoding
//    (IDLE/RUN/HOLD/KILL), WORD_BYTES=4.
//  - Sub-module if_id_reg: IF/ID register with load/flush/hold controls and async
//    active-low reset. FSM, req_addr/target regs and hold buffer stay in fetch_stage.
// TESTING
//  1 reset low 3 cycles, release; memory acks every cycle -> imem_addr 0,4,8,C;
//    IF/ID pc 0,4,8 on consecutive cycles, if_valid=1 from third edge.
//  2 ack latency 3 cycles -> imem_req stays high, imem_addr stable;
//    one IF/ID load per ack; if_valid=0 between loads.
//  3 stall 2 cycles with ack at addr 0x10 -> IF/ID holds 0x0C; HOLD, imem_req=0;
//    after release IF/ID pc=0x10 with acked word, next req 0x14.
//  4 redirect to 0x40 while req 0x20 outstanding -> instruction=NOP, if_valid=0;
//    ack for 0x20 dropped; next imem_addr=0x40, IF/ID pc=0x40.
//  5 stall and redirect same cycle -> redirect ignored, IF/ID and req_addr unchanged.
//    redirect_pc=0x43 -> imem_addr=0x40.
//  6 PC wrap and mid-run reset: req_addr=0xFFFF_FFFC then ack -> pc_plus=0, next addr 0;
//    async reset low mid-request -> all outputs at reset values immediately; stray ack ignored.

Source files
------------

// File: rtl/pipeline_defs.sv
// rtl/pipeline_defs.sv - shared constants and fetch state encoding for the pipeline
// Purpose: single home for the NOP encoding, default reset PC, word size and
//          the IF-stage state enumeration used by fetch_stage.
// Ports:   none (package).
package pipeline_defs;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES       = 32'd4;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,  // waiting one edge after reset release
        FS_RUN  = 2'd1,  // request outstanding for req_addr
        FS_HOLD = 2'd2,  // acked word parked in the hold buffer, no request
        FS_KILL = 2'd3   // request outstanding but stale, response discarded
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load/flush/hold control
// Purpose: holds the instruction handed to decode plus its pc and pc+4.
// Ports:   clk, rst_n (async active-low)
//          load_i     capture instr_i/pc_i/pc_plus_i, mark valid
//          flush_i    replace instruction with NOP, mark bubble (pc fields kept)
//          neither    hold current contents
//          instruction_o, pc_o, pc_plus_o, valid_o  register outputs
module if_id_reg
    import pipeline_defs::*;
#(
    parameter logic [31:0] NOP = NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus_q, pc_plus_d;
    logic        valid_q, valid_d;

    // Flush wins over load so a redirect can never leak a wrong-path word.
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pc_plus_d = pc_plus_q;
        valid_d   = valid_q;
        if (flush_i) begin
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d   = instr_i;
            pc_d      = pc_i;
            pc_plus_d = pc_plus_i;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q   <= NOP;
            pc_q      <= 32'h0;
            pc_plus_q <= 32'h0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pc_plus_q <= pc_plus_d;
            valid_q   <= valid_d;
        end
    end

    assign instruction_o = instr_q;
    assign pc_o          = pc_q;
    assign pc_plus_o     = pc_plus_q;
    assign valid_o       = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS32 IF stage: PC, imem req/ack fetch, IF/ID load
// Purpose: owns the fetch address, talks to instruction memory over req/ack,
//          and feeds the IF/ID register; honours stall and decode redirects.
// Ports:   clk, reset (async active-low)
//          stall                 hold IF/ID and PC this cycle
//          redirect, redirect_pc flush IF/ID and restart fetch at target
//          imem_req/imem_addr    request out, held until imem_ack
//          imem_ack/imem_rdata   one-cycle response from memory
//          instruction, pc, pc_plus, if_valid  IF/ID contents for decode
module fetch_stage
    import pipeline_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP      = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus,
    output logic        if_valid
);

    fetch_state_e state_q, state_d;
    logic [31:0]  req_addr_q, req_addr_d;  // address of the request in flight / next to issue
    logic [31:0]  target_q, target_d;      // redirect target remembered while in KILL
    logic [31:0]  buf_q, buf_d;            // word acked during a stall

    logic [31:0]  target_w;
    logic         ifid_load;
    logic         ifid_flush;
    logic [31:0]  ifid_instr;
    logic         unused_rpc_lsb;

    assign target_w       = {redirect_pc[31:2], 2'b00};
    assign unused_rpc_lsb = ^redirect_pc[1:0];

    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        target_d   = target_q;
        buf_d      = buf_q;
        ifid_load  = 1'b0;
        ifid_instr = buf_q;

        unique case (state_q)
            FS_IDLE: begin
                state_d = FS_RUN;
            end
            FS_RUN: begin
                if (stall) begin
                    // Memory cannot be told to wait, so park the word.
                    if (imem_ack) begin
                        buf_d   = imem_rdata;
                        state_d = FS_HOLD;
                    end
                end else if (redirect) begin
                    if (imem_ack) begin
                        req_addr_d = target_w;
                    end else begin
                        // Request cannot be withdrawn; keep imem_addr steady
                        // and remember where to go once it completes.
                        target_d = target_w;
                        state_d  = FS_KILL;
                    end
                end else if (imem_ack) begin
                    ifid_load  = 1'b1;
                    ifid_instr = imem_rdata;
                    req_addr_d = req_addr_q + WORD_BYTES;
                end
            end
            FS_HOLD: begin
                if (!stall) begin
                    state_d = FS_RUN;
                    if (redirect) begin
                        req_addr_d = target_w;
                    end else begin
                        ifid_load  = 1'b1;
                        req_addr_d = req_addr_q + WORD_BYTES;
                    end
                end
            end
            FS_KILL: begin
                // Stall does not block consuming the stale ack: nothing is
                // loaded into IF/ID from this state anyway.
                if (redirect && !stall) begin
                    if (imem_ack) begin
                        req_addr_d = target_w;
                        state_d    = FS_RUN;
                    end else begin
                        target_d = target_w;
                    end
                end else if (imem_ack) begin
                    req_addr_d = target_q;
                    state_d    = FS_RUN;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase

        // With no stall the IF/ID either takes a new word or becomes a bubble.
        ifid_flush = !stall && !ifid_load;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= FS_IDLE;
            req_addr_q <= RESET_PC;
            target_q   <= 32'h0;
            buf_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            target_q   <= target_d;
            buf_q      <= buf_d;
        end
    end

    assign imem_req  = (state_q == FS_RUN) || (state_q == FS_KILL);
    assign imem_addr = imem_req ? req_addr_q : 32'h0;

    if_id_reg #(
        .NOP(NOP)
    ) u_if_id (
        .clk           (clk),
        .rst_n         (reset),
        .load_i        (ifid_load),
        .flush_i       (ifid_flush),
        .instr_i       (ifid_instr),
        .pc_i          (req_addr_q),
        .pc_plus_i     (req_addr_q + WORD_BYTES),
        .instruction_o (instruction),
        .pc_o          (pc),
        .pc_plus_o     (pc_plus),
        .valid_o       (if_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - table-driven self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] TB_NOP = 32'h0000_0000;
    localparam logic [31:0] SIG    = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        if_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Memory returns a word tagged with its own address.
    assign imem_rdata = imem_addr ^ SIG;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc          (pc),
        .pc_plus     (pc_plus),
        .if_valid    (if_valid)
    );

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        ak;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_v;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " imem_req"}, {31'b0, imem_req}, 32'h0);
        chk({tag, " imem_addr"}, imem_addr, 32'h0);
        chk({tag, " instruction"}, instruction, TB_NOP);
        chk({tag, " pc"}, pc, 32'h0);
        chk({tag, " pc_plus"}, pc_plus, 32'h0);
        chk({tag, " if_valid"}, {31'b0, if_valid}, 32'h0);
    endtask

    task automatic add(input logic st, input logic rd, input logic [31:0] rpc, input logic ak,
                       input logic rq, input logic [31:0] ad, input logic vl, input logic [31:0] p);
        vec_t v;
        v.st = st; v.rd = rd; v.rpc = rpc; v.ak = ak;
        v.exp_req = rq; v.exp_addr = ad; v.exp_v = vl; v.exp_pc = p;
        vq.push_back(v);
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;

        //  st rd rpc            ak   req addr           v  pc
        // sequential fetch, acks from the second request cycle on
        add(0, 0, 32'h0,         0,   1, 32'h0000_0000, 0, 32'h0);
        add(0, 0, 32'h0,         0,   1, 32'h0000_0000, 0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h0000_0004, 1, 32'h0000_0000);
        add(0, 0, 32'h0,         1,   1, 32'h0000_0008, 1, 32'h0000_0004);
        add(0, 0, 32'h0,         1,   1, 32'h0000_000C, 1, 32'h0000_0008);
        // slow memory: bubbles while the request waits
        add(0, 0, 32'h0,         0,   1, 32'h0000_000C, 0, 32'h0);
        add(0, 0, 32'h0,         0,   1, 32'h0000_000C, 0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h0000_0010, 1, 32'h0000_000C);
        // stall with ack at 0x10 -> HOLD, stray ack in HOLD ignored
        add(1, 0, 32'h0,         1,   0, 32'h0000_0000, 1, 32'h0000_000C);
        add(1, 0, 32'h0,         1,   0, 32'h0000_0000, 1, 32'h0000_000C);
        add(0, 0, 32'h0,         0,   1, 32'h0000_0014, 1, 32'h0000_0010);
        add(0, 0, 32'h0,         1,   1, 32'h0000_0018, 1, 32'h0000_0014);
        add(0, 0, 32'h0,         1,   1, 32'h0000_001C, 1, 32'h0000_0018);
        add(0, 0, 32'h0,         1,   1, 32'h0000_0020, 1, 32'h0000_001C);
        add(0, 0, 32'h0,         0,   1, 32'h0000_0020, 0, 32'h0);
        // redirect to 0x40 while 0x20 outstanding -> KILL, stale ack dropped
        add(0, 1, 32'h0000_0040, 0,   1, 32'h0000_0020, 0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h0000_0040, 0, 32'h0);
        add(0, 0, 32'h0,         0,   1, 32'h0000_0040, 0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h0000_0044, 1, 32'h0000_0040);
        // redirect under stall ignored, then re-asserted with unaligned target
        add(1, 1, 32'h0000_0043, 0,   1, 32'h0000_0044, 1, 32'h0000_0040);
        add(0, 1, 32'h0000_0043, 0,   1, 32'h0000_0044, 0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h0000_0040, 0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h0000_0044, 1, 32'h0000_0040);
        // redirect coinciding with ack, then address wrap
        add(0, 1, 32'hFFFF_FFFC, 1,   1, 32'hFFFF_FFFC, 0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h0000_0000, 1, 32'hFFFF_FFFC);
        add(0, 0, 32'h0,         1,   1, 32'h0000_0004, 1, 32'h0000_0000);
        // redirect from HOLD discards the buffered word
        add(1, 0, 32'h0,         1,   0, 32'h0000_0000, 1, 32'h0000_0000);
        add(0, 1, 32'h0000_0080, 0,   1, 32'h0000_0080, 0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h0000_0084, 1, 32'h0000_0080);
        // double redirect in KILL, ack consumed under stall
        add(0, 0, 32'h0,         0,   1, 32'h0000_0084, 0, 32'h0);
        add(0, 1, 32'h0000_0100, 0,   1, 32'h0000_0084, 0, 32'h0);
        add(0, 1, 32'h0000_0200, 0,   1, 32'h0000_0084, 0, 32'h0);
        add(1, 0, 32'h0,         1,   1, 32'h0000_0200, 0, 32'h0);
        add(0, 0, 32'h0,         1,   1, 32'h0000_0204, 1, 32'h0000_0200);

        // reset held for three edges
        repeat (3) @(posedge clk);
        #1;
        chk_reset_values("por");
        reset = 1'b1;

        foreach (vq[i]) begin
            stall       = vq[i].st;
            redirect    = vq[i].rd;
            redirect_pc = vq[i].rpc;
            imem_ack    = vq[i].ak;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vq[i].exp_req});
            chk($sformatf("v%0d imem_addr", i), imem_addr, vq[i].exp_addr);
            chk($sformatf("v%0d if_valid", i), {31'b0, if_valid}, {31'b0, vq[i].exp_v});
            if (vq[i].exp_v) begin
                chk($sformatf("v%0d pc", i), pc, vq[i].exp_pc);
                chk($sformatf("v%0d pc_plus", i), pc_plus, vq[i].exp_pc + 32'd4);
                chk($sformatf("v%0d instruction", i), instruction, vq[i].exp_pc ^ SIG);
            end else begin
                chk($sformatf("v%0d instruction", i), instruction, TB_NOP);
            end
        end

        // async reset in the middle of an outstanding request at 0x204
        stall    = 1'b0;
        redirect = 1'b0;
        imem_ack = 1'b1;
        chk("pre-reset imem_req", {31'b0, imem_req}, 32'h1);
        reset = 1'b0;
        #1;
        chk_reset_values("async");
        @(posedge clk);
        #1;
        chk_reset_values("in-reset");
        // stray ack right after release must not load anything
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post-reset imem_req", {31'b0, imem_req}, 32'h1);
        chk("post-reset imem_addr", imem_addr, 32'h0);
        chk("post-reset if_valid", {31'b0, if_valid}, 32'h0);
        chk("post-reset instruction", instruction, TB_NOP);
        imem_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("post-reset hold addr", imem_addr, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
